// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'b00,
    PRESS_CHECK   = 2'b01,
    PRESSED       = 2'b11,
    RELEASE_CHECK = 2'b10
  } btn_state_e;

  // A counter needs at least one bit even when $clog2 returns 0.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit.
// The chain clears to 0 on a synchronous reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button pin and produces a clean level
// plus single-cycle press, release and long-press pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 10,
  parameter int LONG_PRESS_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

  logic              s;
  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (s)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_CHECK;
          deb_d   = '0;
        end
      end
      PRESS_CHECK: begin
        if (!s) begin
          state_d = RELEASED;
          deb_d   = '0;
        end else if (int'(deb_q) == DEBOUNCE_CYCLES - 1) begin
          state_d = PRESSED;
          deb_d   = '0;
          hold_d  = '0;
          fired_d = 1'b0;
          press_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      PRESSED: begin
        if (int'(hold_q) < LONG_PRESS_CYCLES - 1) begin
          hold_d = hold_q + 1'b1;
        end
        // The sticky flag limits the long-press event to once per press.
        if (int'(hold_q) == LONG_PRESS_CYCLES - 1 && !fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
        if (!s) begin
          state_d = RELEASE_CHECK;
          deb_d   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (s) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (int'(deb_q) == DEBOUNCE_CYCLES - 1) begin
          state_d   = RELEASED;
          deb_d     = '0;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        deb_d   = '0;
        hold_d  = '0;
        fired_d = 1'b0;
      end
    endcase

    level_d = (state_d == PRESSED) || (state_d == RELEASE_CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RELEASED;
      deb_q     <= '0;
      hold_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level        = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: default instance plus a small-parameter instance.
// Observed vectors are {btn_level, press_pulse, release_pulse, long_press_pulse}.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_reset, a_raw, a_level, a_press, a_release, a_long;
  logic b_reset, b_raw, b_level, b_press, b_release, b_long;

  int n_asserts = 0;
  int n_fail    = 0;

  button_conditioner dut_a (
    .clk              (clk),
    .reset            (a_reset),
    .btn_raw          (a_raw),
    .btn_level        (a_level),
    .press_pulse      (a_press),
    .release_pulse    (a_release),
    .long_press_pulse (a_long)
  );

  button_conditioner #(
    .SYNC_STAGES       (3),
    .DEBOUNCE_CYCLES   (2),
    .LONG_PRESS_CYCLES (4)
  ) dut_b (
    .clk              (clk),
    .reset            (b_reset),
    .btn_raw          (b_raw),
    .btn_level        (b_level),
    .press_pulse      (b_press),
    .release_pulse    (b_release),
    .long_press_pulse (b_long)
  );

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] vec(input logic l, input logic p, input logic r, input logic g);
    return {l, p, r, g};
  endfunction

  initial begin
    a_reset = 1'b1; a_raw = 1'b0;
    b_reset = 1'b1; b_raw = 1'b0;
    tick();
    tick();
    check("a_reset", {a_level, a_press, a_release, a_long}, 4'b0000);
    check("b_reset", {b_level, b_press, b_release, b_long}, 4'b0000);
    a_reset = 1'b0;
    b_reset = 1'b0;
    tick();
    tick();
    check("a_idle", {a_level, a_press, a_release, a_long}, 4'b0000);

    // Clean press held 70 edges: press after edge 12, long press after edge 62.
    for (int k = 0; k < 70; k++) begin
      a_raw = 1'b1;
      tick();
      check($sformatf("clean_hold[%0d]", k), {a_level, a_press, a_release, a_long},
            vec(k >= 12, k == 12, 1'b0, k == 62));
    end

    // Release: level drops together with release_pulse after edge 12.
    for (int j = 0; j < 20; j++) begin
      a_raw = 1'b0;
      tick();
      check($sformatf("release[%0d]", j), {a_level, a_press, a_release, a_long},
            vec(j < 12, 1'b0, j == 12, 1'b0));
    end

    // Bounce every 3 edges until edge 18, then steady high: press after edge 30.
    // A 5-edge dropout at edges 40..44 stretches the long press from 80 to 85.
    for (int i = 0; i < 100; i++) begin
      if (i < 18)      a_raw = ((i / 3) % 2) == 0;
      else if (i < 40) a_raw = 1'b1;
      else if (i < 45) a_raw = 1'b0;
      else             a_raw = 1'b1;
      tick();
      check($sformatf("bounce_glitch[%0d]", i), {a_level, a_press, a_release, a_long},
            vec(i >= 30, i == 30, 1'b0, i == 85));
    end

    // Reset while held: everything clears, then a fresh press after 12 edges.
    a_reset = 1'b1;
    tick();
    check("mid_press_reset", {a_level, a_press, a_release, a_long}, 4'b0000);
    a_reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      check($sformatf("after_reset[%0d]", k), {a_level, a_press, a_release, a_long},
            vec(k >= 12, k == 12, 1'b0, 1'b0));
    end

    // Small parameters: press after edge 5, long press after edge 9.
    for (int k = 0; k < 16; k++) begin
      b_raw = 1'b1;
      tick();
      check($sformatf("sweep_press[%0d]", k), {b_level, b_press, b_release, b_long},
            vec(k >= 5, k == 5, 1'b0, k == 9));
    end
    for (int j = 0; j < 10; j++) begin
      b_raw = 1'b0;
      tick();
      check($sformatf("sweep_release[%0d]", j), {b_level, b_press, b_release, b_long},
            vec(j < 5, 1'b0, j == 5, 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
